// File: rtl/uart_rx_fifo.sv
// Purpose: buffers bytes from a UART receiver in a DEPTH-entry ring and exposes them on a simple CPU bus (DATA at 0x0, STATUS at 0x4).
// Latency: a byte pushed at edge N is visible to a DATA read issued from the next cycle on; bus accesses complete with mem_ready one cycle after the request is sampled.
// Backpressure: none toward the receiver (bytes arriving while full are dropped and flagged); the bus side never stalls beyond the fixed one-cycle response.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]    ADDR_DATA   = 4'h0;
  localparam logic [3:0]    ADDR_STATUS = 4'h4;

  // Storage and state
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_irq;

  // Decoded request and next-state values
  logic          w_req;
  logic          w_read;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_flush;
  logic          w_clr;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata_nxt;
  logic [AW:0]   w_count_nxt;
  logic          w_unused_wdata;

  assign w_unused_wdata = ^{mem_wdata[31:20], mem_wdata[17:0]};

  // Bus decode, push/pop arbitration and the registered read-data value
  always_comb begin
    w_req       = mem_valid & ~r_ready;  // a request is accepted once; the ack cycle itself is never a new request
    w_read      = (mem_wstrb == 4'b0000);
    w_empty     = (r_count == '0);
    w_full      = (r_count == FULL_CNT);
    w_pop       = w_req & w_read & (mem_addr == ADDR_DATA) & ~w_empty;
    w_flush     = w_req & ~w_read & (mem_addr == ADDR_STATUS) & mem_wstrb[2] & mem_wdata[19];
    w_clr       = w_req & ~w_read & (mem_addr == ADDR_STATUS) & mem_wstrb[2] & mem_wdata[18];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept; flush discards everything including the incoming byte.
    w_push      = rx_valid & (~w_full | w_pop) & ~w_flush;
    w_drop      = rx_valid & w_full & ~w_pop & ~w_flush;

    w_status        = '0;
    w_status[AW:0]  = r_count;
    w_status[16]    = w_empty;
    w_status[17]    = w_full;
    w_status[18]    = r_ovf;

    w_rdata_nxt = '0;
    if (w_req && w_read) begin
      if (mem_addr == ADDR_DATA) begin
        w_rdata_nxt = w_empty ? 32'hFFFF_FFFF : {24'h0, r_mem[r_rd_ptr]};
      end else if (mem_addr == ADDR_STATUS) begin
        w_rdata_nxt = w_status;  // snapshot before any same-cycle push
      end
    end

    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Pointers, occupancy and overflow flag; flush and reset return the ring to empty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Setting has priority so a byte lost in the clearing cycle stays visible.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Byte storage; contents are unreachable while empty so they are not reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  // Single-cycle bus acknowledge with read data, plus registered interrupt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ready <= w_req;
      r_rdata <= w_rdata_nxt;
      r_irq   <= (r_count != '0);
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; power of two, 4..256.
REQ-002 Parameter AW = log2(DEPTH), derived, not overridden.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid in that cycle.
REQ-007 mem_valid  input  1  bus request from CPU; held until mem_ready.
REQ-008 mem_addr  input  4  byte offset within block (0x0 DATA, 0x4 STATUS).
REQ-009 mem_wstrb  input  4  byte write strobes; all zero = read.
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_ready  output  1  transfer complete, one-cycle pulse.
REQ-012 mem_rdata  output  32  read data, valid while mem_ready high.
REQ-013 irq  output  1  high while FIFO non-empty.

Function
REQ-014 Storage: DEPTH x 8 ring buffer; wr_ptr, rd_ptr AW bits wrapping DEPTH-1 -> 0; count AW+1 bits, 0..DEPTH.
REQ-015 Push: rx_valid=1 and (count<DEPTH or a pop occurs the same cycle) -> byte stored at wr_ptr, wr_ptr+1.
REQ-016 Drop: rx_valid=1, count=DEPTH, no pop that cycle -> byte discarded, overflow flag set, pointers unchanged.
REQ-017 Bus: mem_ready asserted exactly one cycle, in the cycle after mem_valid is first sampled high with mem_ready low; never two consecutive cycles; mem_rdata is 0 whenever mem_ready is low.
REQ-018 DATA read (0x0, wstrb=0): non-empty -> rdata = {24'h0, head byte}, rd_ptr+1 at the mem_ready edge; empty -> rdata = 32'hFFFF_FFFF, no pop.
REQ-019 STATUS read (0x4, wstrb=0): rdata[AW:0]=count, [16]=empty, [17]=full, [18]=overflow, other bits 0; no side effects.
REQ-020 STATUS write (0x4, wstrb[2]=1): wdata[18]=1 clears overflow; wdata[19]=1 flushes (pointers and count to 0); both act at the mem_ready edge.
REQ-021 DATA writes, and any access to offsets other than 0x0/0x4: acknowledged normally, no side effect, rdata 0.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance; popped byte is the old head.
REQ-023 Pop when empty with push same cycle: returns 32'hFFFF_FFFF, pushed byte retained, count becomes 1.
REQ-024 Overflow set and clear in the same cycle: set wins, flag remains 1.
REQ-025 Flush and push in the same cycle: flush wins, byte discarded, overflow not set.
REQ-026 irq registered: reflects count!=0 one cycle after count changes.
REQ-027 Snapshot rules: STATUS read returns the value before any same-cycle push; DATA read returns the pre-push head.

Reset
REQ-028 resetn low -> pointers, count, overflow, mem_ready, mem_rdata, irq = 0 immediately, independent of clk.
REQ-029 A transaction in progress at reset is abandoned; after release the master re-issues it, and the block treats mem_valid as a new request.
REQ-030 Buffer contents need not be cleared; they are unreachable while count=0.
REQ-031 resetn released synchronously by upstream reset generator; block operates from the first clk edge after release.

Verification
REQ-032 Reset, then STATUS read -> rdata=0x0001_0000 (empty), irq=0, mem_ready exactly one cycle after mem_valid.
REQ-033 Push 0x41,0x42,0x43, then 3 DATA reads -> 0x41,0x42,0x43; 4th read -> 0xFFFF_FFFF; irq low after 3rd pop.
REQ-034 Push 17 bytes (DEPTH=16) -> STATUS=0x0006_0010 (full+overflow, count 16); 17th byte absent on readout; write 0x0004_0000 to STATUS -> overflow 0.
REQ-035 FIFO full, pop and rx_valid in the same cycle -> count stays 16, no overflow; push 20 bytes, pop 20 with pointer wrap -> order preserved.
REQ-036 Three bytes stored, write 0x0008_0000 to STATUS -> count 0, irq 0 on next cycle, DATA read -> 0xFFFF_FFFF.
REQ-037 resetn asserted while mem_valid high and before mem_ready -> mem_ready stays 0; after release, re-issued STATUS read -> 0x0001_0000.
